// File: rtl/sccb_init_sequencer_if.sv
// Bus between the init sequencer, its config ROM and the SCCB master.
// The master modport is the sequencer side; the slave modport is the ROM/SCCB side.
interface sccb_init_sequencer_if #(
    parameter int ROM_AW = 8
);
    logic [ROM_AW-1:0] rom_addr;
    logic [15:0]       rom_data;
    logic              sccb_start;
    logic [23:0]       sccb_indata;
    logic              sccb_done;

    modport master (
        output rom_addr, sccb_start, sccb_indata,
        input  rom_data, sccb_done
    );

    modport slave (
        input  rom_addr, sccb_start, sccb_indata,
        output rom_data, sccb_done
    );
endinterface

// File: rtl/sccb_init_sequencer.sv
// Walks a camera register table and issues each entry as one SCCB write,
// with delay entries, per-write timeout and an overrun halt.
module sccb_init_sequencer #(
    parameter logic [7:0] SLAVE_ADDR = 8'h42,
    parameter int ROM_AW     = 8,
    parameter int PWR_WAIT   = 400,
    parameter int GAP_CYCLES = 4,
    parameter int DELAY_UNIT = 400,
    parameter int TIMEOUT    = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rerun,
    sccb_init_sequencer_if.master bus,
    output logic                  busy,
    output logic                  init_done,
    output logic                  err,
    output logic [7:0]            err_count
);
    typedef enum logic [3:0] {
        PWR, FETCH, DECODE, ISSUE, WAIT, GAP, DLY, DONE, ERR_HALT
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
    logic              start_q, start_d;
    logic [23:0]       indata_q, indata_d;
    logic              busy_q, busy_d;
    logic              init_done_q, init_done_d;
    logic              err_q, err_d;
    logic [7:0]        err_count_q, err_count_d;
    logic              adv;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rom_addr_d  = rom_addr_q;
        start_d     = 1'b0;
        indata_d    = indata_q;
        busy_d      = busy_q;
        init_done_d = init_done_q;
        err_d       = err_q;
        err_count_d = err_count_q;
        adv         = 1'b0;

        case (state_q)
            PWR: begin
                if (cnt_q >= 32'(PWR_WAIT - 1)) begin
                    cnt_d   = '0;
                    state_d = FETCH;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            FETCH: state_d = DECODE;
            DECODE: begin
                if (bus.rom_data == 16'hFFFF) begin
                    state_d     = DONE;
                    busy_d      = 1'b0;
                    init_done_d = 1'b1;
                end else if (bus.rom_data[15:8] == 8'hFE) begin
                    if (bus.rom_data[7:0] == 8'h00) begin
                        adv = 1'b1;
                    end else begin
                        cnt_d   = 32'(bus.rom_data[7:0]) * 32'(DELAY_UNIT);
                        state_d = DLY;
                    end
                end else begin
                    indata_d = {SLAVE_ADDR, bus.rom_data};
                    start_d  = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // done wins over a timeout landing in the same cycle
                if (bus.sccb_done) begin
                    cnt_d   = '0;
                    state_d = GAP;
                end else if (cnt_q >= 32'(TIMEOUT - 1)) begin
                    err_d = 1'b1;
                    if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
                    cnt_d   = '0;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            GAP: begin
                if (cnt_q >= 32'(GAP_CYCLES - 1)) adv = 1'b1;
                else                               cnt_d = cnt_q + 32'd1;
            end
            DLY: begin
                if (cnt_q <= 32'd1) adv = 1'b1;
                else                cnt_d = cnt_q - 32'd1;
            end
            DONE, ERR_HALT: begin
                if (rerun) begin
                    rom_addr_d  = '0;
                    init_done_d = 1'b0;
                    busy_d      = 1'b1;
                    cnt_d       = '0;
                    state_d     = PWR;
                end
            end
            default: state_d = PWR;
        endcase

        // Stepping past the last table slot without an end marker is an overrun.
        if (adv) begin
            cnt_d = '0;
            if (rom_addr_q == '1) begin
                state_d     = ERR_HALT;
                err_d       = 1'b1;
                busy_d      = 1'b0;
                init_done_d = 1'b0;
            end else begin
                rom_addr_d = rom_addr_q + 1'b1;
                state_d    = FETCH;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= PWR;
            cnt_q       <= '0;
            rom_addr_q  <= '0;
            start_q     <= 1'b0;
            indata_q    <= '0;
            busy_q      <= 1'b1;
            init_done_q <= 1'b0;
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rom_addr_q  <= rom_addr_d;
            start_q     <= start_d;
            indata_q    <= indata_d;
            busy_q      <= busy_d;
            init_done_q <= init_done_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.rom_addr    = rom_addr_q;
    assign bus.sccb_start  = start_q;
    assign bus.sccb_indata = indata_q;
    assign busy            = busy_q;
    assign init_done       = init_done_q;
    assign err             = err_q;
    assign err_count       = err_count_q;
endmodule

// File: tb/tb_sccb_init_sequencer.sv
// Scoreboarded bench: expected SCCB writes (data + cycle) are queued by the
// stimulus thread and popped by per-instance monitors on each sccb_start.
module tb_sccb_init_sequencer;
    typedef struct {
        logic [23:0] data;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst_a, rst_b, rerun_a, rerun_b;
    logic busy_a, init_done_a, err_a, busy_b, init_done_b, err_b;
    logic [7:0] err_count_a, err_count_b;
    int n_vec, n_bad;
    int cyc_a, cyc_b, done_at_a, done_at_b, starts_b, drop_idx_b;
    exp_t q_a[$];
    exp_t q_b[$];
    logic [15:0] rom_a [0:255];
    logic [15:0] rom_b [0:3];

    sccb_init_sequencer_if #(.ROM_AW(8)) if_a ();
    sccb_init_sequencer_if #(.ROM_AW(2)) if_b ();

    sccb_init_sequencer #(
        .SLAVE_ADDR(8'h42), .ROM_AW(8), .PWR_WAIT(10), .GAP_CYCLES(4),
        .DELAY_UNIT(5), .TIMEOUT(1023)
    ) dut_a (
        .clk(clk), .rst(rst_a), .rerun(rerun_a), .bus(if_a.master),
        .busy(busy_a), .init_done(init_done_a), .err(err_a), .err_count(err_count_a)
    );

    sccb_init_sequencer #(
        .SLAVE_ADDR(8'h42), .ROM_AW(2), .PWR_WAIT(10), .GAP_CYCLES(4),
        .DELAY_UNIT(5), .TIMEOUT(20)
    ) dut_b (
        .clk(clk), .rst(rst_b), .rerun(rerun_b), .bus(if_b.master),
        .busy(busy_b), .init_done(init_done_b), .err(err_b), .err_count(err_count_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst_a)
        if (rst_a) cyc_a <= 0; else cyc_a <= cyc_a + 1;
    always @(posedge clk or posedge rst_b)
        if (rst_b) cyc_b <= 0; else cyc_b <= cyc_b + 1;

    always @(posedge clk) if_a.rom_data <= rom_a[if_a.rom_addr];
    always @(posedge clk) if_b.rom_data <= rom_b[if_b.rom_addr];

    // SCCB slave A answers 30 cycles after each start.
    always @(negedge clk) begin
        if (rst_a) begin
            done_at_a      <= -1;
            if_a.sccb_done <= 1'b0;
        end else begin
            if_a.sccb_done <= (cyc_a == done_at_a);
            if (if_a.sccb_start) done_at_a <= cyc_a + 30;
        end
    end

    // SCCB slave B answers after 5 cycles, except for start number drop_idx_b.
    always @(negedge clk) begin
        if (rst_b) begin
            done_at_b      <= -1;
            starts_b       <= 0;
            if_b.sccb_done <= 1'b0;
        end else begin
            if_b.sccb_done <= (cyc_b == done_at_b);
            if (if_b.sccb_start) begin
                starts_b <= starts_b + 1;
                if (starts_b != drop_idx_b) done_at_b <= cyc_b + 5;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_a && if_a.sccb_start) begin
            if (q_a.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL a_unexpected_start: got start %0h at cycle %0d, expected none",
                         if_a.sccb_indata, cyc_a);
            end else begin
                e = q_a.pop_front();
                check("a_start_data", 32'(if_a.sccb_indata), 32'(e.data));
                check("a_start_cycle", 32'(cyc_a), 32'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_b && if_b.sccb_start) begin
            if (q_b.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL b_unexpected_start: got start %0h at cycle %0d, expected none",
                         if_b.sccb_indata, cyc_b);
            end else begin
                e = q_b.pop_front();
                check("b_start_data", 32'(if_b.sccb_indata), 32'(e.data));
                check("b_start_cycle", 32'(cyc_b), 32'(e.cyc));
            end
        end
    end

    task automatic push_a(input logic [23:0] d, input int c);
        exp_t e;
        e.data = d;
        e.cyc  = c;
        q_a.push_back(e);
    endtask

    task automatic push_b(input logic [23:0] d, input int c);
        exp_t e;
        e.data = d;
        e.cyc  = c;
        q_b.push_back(e);
    endtask

    task automatic load_a(input logic [15:0] t0, t1, t2, t3);
        for (int i = 0; i < 256; i++) rom_a[i] = 16'hFFFF;
        rom_a[0] = t0; rom_a[1] = t1; rom_a[2] = t2; rom_a[3] = t3;
    endtask

    task automatic wait_a(input int c);
        while (cyc_a < c) @(negedge clk);
    endtask

    task automatic wait_b(input int c);
        while (cyc_b < c) @(negedge clk);
    endtask

    initial begin
        clk = 1'b0; rst_a = 1'b1; rst_b = 1'b1;
        rerun_a = 1'b0; rerun_b = 1'b0;
        n_vec = 0; n_bad = 0; drop_idx_b = -1;
        load_a(16'h1280, 16'h1100, 16'hFFFF, 16'hFFFF);
        rom_b[0] = 16'h1280; rom_b[1] = 16'h1100; rom_b[2] = 16'hFFFF; rom_b[3] = 16'h0000;
        repeat (3) @(negedge clk);

        check("rst_rom_addr", 32'(if_a.rom_addr), 32'd0);
        check("rst_start", 32'(if_a.sccb_start), 32'd0);
        check("rst_indata", 32'(if_a.sccb_indata), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd1);
        check("rst_init_done", 32'(init_done_a), 32'd0);
        check("rst_err", 32'(err_a), 32'd0);
        check("rst_err_count", 32'(err_count_a), 32'd0);

        // Two plain writes, 30-cycle slave
        push_a(24'h421280, 12);
        push_a(24'h421100, 49);
        rst_a = 1'b0;
        wait_a(30);
        rerun_a = 1'b1;
        @(negedge clk);
        rerun_a = 1'b0;
        wait_a(50);
        check("a_busy_mid", 32'(busy_a), 32'd1);
        check("a_init_done_mid", 32'(init_done_a), 32'd0);
        wait_a(90);
        check("a_busy_end", 32'(busy_a), 32'd0);
        check("a_init_done_end", 32'(init_done_a), 32'd1);
        check("a_err_end", 32'(err_a), 32'd0);
        check("a_err_count_end", 32'(err_count_a), 32'd0);

        // Rerun from DONE
        wait_a(95);
        push_a(24'h421280, 108);
        rerun_a = 1'b1;
        @(negedge clk);
        rerun_a = 1'b0;
        check("a_rerun_rom_addr", 32'(if_a.rom_addr), 32'd0);
        check("a_rerun_busy", 32'(busy_a), 32'd1);
        check("a_rerun_init_done", 32'(init_done_a), 32'd0);

        // Asynchronous reset while waiting on the first write
        wait_a(120);
        rst_a = 1'b1;
        #1;
        check("a_arst_indata", 32'(if_a.sccb_indata), 32'd0);
        check("a_arst_start", 32'(if_a.sccb_start), 32'd0);
        check("a_arst_rom_addr", 32'(if_a.rom_addr), 32'd0);
        check("a_arst_busy", 32'(busy_a), 32'd1);

        // Restart with a 3-unit delay entry (15 cycles) between the writes
        load_a(16'h1280, 16'hFE03, 16'h1100, 16'hFFFF);
        repeat (2) @(negedge clk);
        push_a(24'h421280, 12);
        push_a(24'h421100, 66);
        rst_a = 1'b0;
        wait_a(110);
        check("a_dly_init_done", 32'(init_done_a), 32'd1);
        check("a_dly_busy", 32'(busy_a), 32'd0);
        check("a_dly_err", 32'(err_a), 32'd0);
        rst_a = 1'b1;

        // B: first write never answered, TIMEOUT=20
        drop_idx_b = 0;
        push_b(24'h421280, 12);
        push_b(24'h421100, 39);
        @(negedge clk);
        rst_b = 1'b0;
        wait_b(32);
        check("b_err_before_timeout", 32'(err_b), 32'd0);
        wait_b(33);
        check("b_err_at_timeout", 32'(err_b), 32'd1);
        check("b_err_count_at_timeout", 32'(err_count_b), 32'd1);
        wait_b(60);
        check("b_to_init_done", 32'(init_done_b), 32'd1);
        check("b_to_busy", 32'(busy_b), 32'd0);
        check("b_to_err_count", 32'(err_count_b), 32'd1);

        // Rerun keeps err/err_count
        push_b(24'h421280, 73);
        push_b(24'h421100, 85);
        rerun_b = 1'b1;
        @(negedge clk);
        rerun_b = 1'b0;
        wait_b(105);
        check("b_rerun_init_done", 32'(init_done_b), 32'd1);
        check("b_rerun_err", 32'(err_b), 32'd1);
        check("b_rerun_err_count", 32'(err_count_b), 32'd1);

        // B: table with no end marker overruns into ERR_HALT
        rst_b = 1'b1;
        drop_idx_b = -1;
        rom_b[0] = 16'h1280; rom_b[1] = 16'h1100; rom_b[2] = 16'h1300; rom_b[3] = 16'h1400;
        repeat (2) @(negedge clk);
        push_b(24'h421280, 12);
        push_b(24'h421100, 24);
        push_b(24'h421300, 36);
        push_b(24'h421400, 48);
        rst_b = 1'b0;
        wait_b(70);
        check("b_halt_busy", 32'(busy_b), 32'd0);
        check("b_halt_init_done", 32'(init_done_b), 32'd0);
        check("b_halt_err", 32'(err_b), 32'd1);
        check("b_halt_err_count", 32'(err_count_b), 32'd0);
        check("b_halt_rom_addr", 32'(if_b.rom_addr), 32'd3);

        check("a_queue_drained", 32'(q_a.size()), 32'd0);
        check("b_queue_drained", 32'(q_b.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/sccb_init_sequencer.md
Name: sccb_init_sequencer

Overview:
- Walks a register-write table and issues each entry as one 3-byte SCCB write through the i2c_sccb master, then waits for its done pulse.
- Configures one camera after power-up, or again on request. Sits between the camera-config ROM and the SCCB master.
- Runs on the same clock as the SCCB master (400 kHz tick clock), so no CDC is needed.

Parameters:
- SLAVE_ADDR, 8'h42, SCCB write address placed in indata[23:16].
- ROM_AW, 8, table address width; the table depth is 2**ROM_AW entries.
- PWR_WAIT, 400, cycles to wait after reset or a rerun before the first fetch.
- GAP_CYCLES, 4, idle cycles between a done pulse and the next fetch.
- DELAY_UNIT, 400, cycles per unit of a delay entry.
- TIMEOUT, 1023, maximum cycles from sccb_start to sccb_done.

Ports:
- clk  in  1  system clock (SCCB tick clock).
- rst  in  1  asynchronous reset, active-high.
- rerun  in  1  one-cycle pulse that restarts the sequence; honoured only in DONE or ERR_HALT.
- rom_addr  out  ROM_AW  table read address.
- rom_data  in  16  table entry {reg_addr[15:8], value[7:0]}; valid one cycle after rom_addr.
- sccb_start  out  1  one-cycle request to the SCCB master.
- sccb_indata  out  24  {SLAVE_ADDR, reg_addr, value}.
- sccb_done  in  1  completion pulse from the SCCB master.
- busy  out  1  high while the sequence is in progress.
- init_done  out  1  sticky; high once the end marker has been reached.
- err  out  1  sticky; high if any write timed out.
- err_count  out  8  number of timeouts; saturates at 255.

Behaviour:
- Reset values: rom_addr 0, sccb_start 0, sccb_indata 0, busy 1, init_done 0, err 0, err_count 0, state PWR.
- Entry encoding:
  - 16'hFFFF is the end marker.
  - reg_addr 8'hFE is a delay entry: wait value*DELAY_UNIT cycles, no bus transaction. A value of 0 gives no wait.
  - Any other entry is a register write.
- State machine:
  - PWR: count PWR_WAIT cycles, then go to FETCH.
  - FETCH: drive rom_addr, go to DECODE.
  - DECODE: sample rom_data.
    - End marker goes to DONE.
    - Delay entry loads the counter and goes to DLY.
    - Otherwise latch sccb_indata and go to ISSUE.
  - ISSUE: sccb_start=1 for exactly this one cycle. Clear the timeout counter. Go to WAIT.
  - WAIT:
    - sccb_done goes to GAP.
    - If the counter reaches TIMEOUT first: set err, increment err_count (saturating), and go to GAP. The entry is skipped, not retried.
  - GAP: wait GAP_CYCLES cycles, increment rom_addr, go to FETCH.
  - DLY: count down to zero, increment rom_addr, go to FETCH.
  - DONE: busy=0, init_done=1. On rerun: clear rom_addr and init_done, set busy, go to PWR. err and err_count are kept.
  - ERR_HALT: entered only when rom_addr is 2**ROM_AW-1 and that entry is not the end marker, i.e. the table overruns without an end marker. Sets err, busy=0, init_done=0. rerun behaves as it does in DONE.
- sccb_indata holds stable from ISSUE until the next DECODE that carries a write entry.
- sccb_done is ignored outside WAIT. A done pulse in the same cycle as a timeout counts as done.
- rerun is ignored while busy.
- At most one transaction is outstanding at a time. sccb_start is never asserted again before done, timeout, and GAP have all completed.
- Reset asserted mid-transaction returns the block to PWR immediately, with the reset values above. The SCCB master shares the same reset.

Test Plan:
- Table {0x1280, 0x1100, 0xFFFF}, sim params PWR_WAIT=10, GAP=4, a model SCCB slave that answers done 30 cycles after start:
  - two sccb_start pulses, with sccb_indata = 24'h421280 then 24'h421100;
  - first start in cycle 12 after reset release;
  - init_done=1 and busy=0 after the end marker; err=0.
- Delay entry 0xFE03 with DELAY_UNIT=5 between two writes: exactly 15 DLY cycles, and no sccb_start during them.
- Model never returns done on the first write, TIMEOUT=20:
  - err=1 and err_count=1 after 20 cycles;
  - the second write is still issued;
  - init_done=1 at the end.
- Table with no end marker, ROM_AW=2: ERR_HALT after entry 3; busy=0, init_done=0, err=1.
- rerun pulse during busy is ignored. rerun in DONE restarts: rom_addr=0, PWR wait, both writes reissued, err_count unchanged.
- rst asserted during WAIT: outputs return to reset values asynchronously. After release, the sequence restarts from entry 0.
